conv_loop_scheduler: RTL and testbench

Loop-nest sequencer for the convolution address generator. Produces the (m, r, c, n, i, j) index tuple each cycle in fixed nested order, from which the address controller derives ifm_addr and weight_addr. Also generates first-tap and last-tap markers, and a delayed output-buffer write strobe and address aligned to the accumulator pipeline. Includes a go/busy/done handshake for the layer-level sequencer.

---
 rtl/conv_loop_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_conv_loop_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_scheduler.sv
// Loop-nest sequencer for the convolution address generator: issues (m,r,c,n,i,j)
// tuples in nested order with tap markers and a latency-aligned output-buffer write.
module conv_loop_scheduler #(
  parameter int K           = 5,
  parameter int OUT_SIZE    = 28,
  parameter int OUT_CHANNEL = 6,
  parameter int IN_CHANNEL  = 1,
  parameter int TN          = 4,
  parameter int PIPE_LAT    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        stall,
  output logic [7:0]  m,
  output logic [7:0]  r,
  output logic [7:0]  c,
  output logic [7:0]  n,
  output logic [3:0]  i,
  output logic [3:0]  j,
  output logic        idx_valid,
  output logic        first_tap,
  output logic        last_tap,
  output logic        out_wea,
  output logic [15:0] out_addr,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] K_LAST   = 4'(K - 1);
  localparam logic [7:0] OS_LAST  = 8'(OUT_SIZE - 1);
  localparam logic [7:0] OC_LAST  = 8'(OUT_CHANNEL - 1);
  localparam logic [7:0] TN_STEP  = 8'(TN);
  localparam logic [8:0] IN_CH    = 9'(IN_CHANNEL);
  localparam int         DRAIN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_m, r_r, r_c, r_n;
  logic [3:0]  r_i, r_j;
  logic [15:0] r_pix;
  logic [DRAIN_W-1:0] r_drain;
  logic [PIPE_LAT-1:0]       r_pv;
  logic [PIPE_LAT-1:0][15:0] r_pa;

  logic w_idx_valid;
  logic w_j_wrap, w_i_wrap, w_n_last, w_c_wrap, w_r_wrap, w_m_last;
  logic w_first_tap, w_last_tap, w_final;

  // Wrap detection and tap markers, all derived from the registered indices
  always_comb begin
    w_idx_valid = (r_state == S_RUN) && !stall;
    w_j_wrap    = (r_j == K_LAST);
    w_i_wrap    = (r_i == K_LAST);
    w_n_last    = (({1'b0, r_n} + {1'b0, TN_STEP}) >= IN_CH);
    w_c_wrap    = (r_c == OS_LAST);
    w_r_wrap    = (r_r == OS_LAST);
    w_m_last    = (r_m == OC_LAST);
    w_first_tap = w_idx_valid && (r_n == 8'd0) && (r_i == 4'd0) && (r_j == 4'd0);
    w_last_tap  = w_idx_valid && w_n_last && w_i_wrap && w_j_wrap;
    w_final     = w_last_tap && w_c_wrap && w_r_wrap && w_m_last;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (go) w_next = S_RUN;
        else    w_next = S_IDLE;
      end
      S_RUN: begin
        if (w_final) w_next = S_DRAIN;
        else         w_next = S_RUN;
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) w_next = S_DONE;
        else                       w_next = S_DRAIN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and drain-length counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DRAIN) r_drain <= r_drain + DRAIN_W'(1);
      else                    r_drain <= '0;
    end
  end

  // Index counters: j innermost, carrying out through i, n, c, r to m
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m <= 8'd0; r_r <= 8'd0; r_c <= 8'd0; r_n <= 8'd0;
      r_i <= 4'd0; r_j <= 4'd0;
    end else if (r_state == S_IDLE && go) begin
      r_m <= 8'd0; r_r <= 8'd0; r_c <= 8'd0; r_n <= 8'd0;
      r_i <= 4'd0; r_j <= 4'd0;
    end else if (w_idx_valid) begin
      if (!w_j_wrap) begin
        r_j <= r_j + 4'd1;
      end else begin
        r_j <= 4'd0;
        if (!w_i_wrap) begin
          r_i <= r_i + 4'd1;
        end else begin
          r_i <= 4'd0;
          if (!w_n_last) begin
            r_n <= r_n + TN_STEP;
          end else begin
            r_n <= 8'd0;
            if (!w_c_wrap) begin
              r_c <= r_c + 8'd1;
            end else begin
              r_c <= 8'd0;
              if (!w_r_wrap) begin
                r_r <= r_r + 8'd1;
              end else begin
                r_r <= 8'd0;
                if (!w_m_last) r_m <= r_m + 8'd1;
                else           r_m <= 8'd0;
              end
            end
          end
        end
      end
    end
  end

  // Pixel address follows loop order, so a running count equals m*S*S + r*S + c
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pix <= 16'd0;
    end else if (r_state == S_IDLE && go) begin
      r_pix <= 16'd0;
    end else if (w_last_tap) begin
      r_pix <= r_pix + 16'd1;
    end
  end

  // Write pipeline: shifts every cycle; addresses only move with a valid entry so
  // the tail address holds its last written value
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pv <= '0;
      r_pa <= '0;
    end else begin
      r_pv[0] <= w_last_tap;
      if (w_last_tap) r_pa[0] <= r_pix;
      for (int k = 1; k < PIPE_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) r_pa[k] <= r_pa[k-1];
      end
    end
  end

  assign m         = r_m;
  assign r         = r_r;
  assign c         = r_c;
  assign n         = r_n;
  assign i         = r_i;
  assign j         = r_j;
  assign idx_valid = w_idx_valid;
  assign first_tap = w_first_tap;
  assign last_tap  = w_last_tap;
  assign out_wea   = r_pv[PIPE_LAT-1];
  assign out_addr  = r_pa[PIPE_LAT-1];
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Scoreboard bench for conv_loop_scheduler: a reference loop nest predicts every
// issued tuple and every output-buffer write, with its cycle.
module tb_conv_loop_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, go_a, stall_a, go_b, stall_b;

  logic [7:0]  m_a, r_a, c_a, n_a, m_b, r_b, c_b, n_b;
  logic [3:0]  i_a, j_a, i_b, j_b;
  logic        iv_a, ft_a, lt_a, we_a, busy_a, done_a;
  logic        iv_b, ft_b, lt_b, we_b, busy_b, done_b;
  logic [15:0] addr_a, addr_b;

  conv_loop_scheduler #(.K(2), .OUT_SIZE(2), .OUT_CHANNEL(2), .IN_CHANNEL(1), .TN(4), .PIPE_LAT(3)) u_a (
    .clock(clk), .reset(reset), .go(go_a), .stall(stall_a),
    .m(m_a), .r(r_a), .c(c_a), .n(n_a), .i(i_a), .j(j_a),
    .idx_valid(iv_a), .first_tap(ft_a), .last_tap(lt_a),
    .out_wea(we_a), .out_addr(addr_a), .busy(busy_a), .done(done_a));

  conv_loop_scheduler #(.K(2), .OUT_SIZE(2), .OUT_CHANNEL(2), .IN_CHANNEL(6), .TN(4), .PIPE_LAT(3)) u_b (
    .clock(clk), .reset(reset), .go(go_b), .stall(stall_b),
    .m(m_b), .r(r_b), .c(c_b), .n(n_b), .i(i_b), .j(j_b),
    .idx_valid(iv_b), .first_tap(ft_b), .last_tap(lt_b),
    .out_wea(we_b), .out_addr(addr_b), .busy(busy_b), .done(done_b));

  typedef struct packed { int cyc; logic [41:0] tup; } tup_t;
  typedef struct packed { int cyc; logic [15:0] addr; } wr_t;

  tup_t q_tup[$];
  wr_t  q_wr[$];
  int   done_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   wea_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference loop nest for K=2, OUT_SIZE=2, OUT_CHANNEL=2, TN=4, PIPE_LAT=3
  task automatic push_pass(input int base, input int inch, input int st_at, input int st_len);
    int k = 0;
    for (int mm = 0; mm < 2; mm++)
      for (int rr = 0; rr < 2; rr++)
        for (int cc = 0; cc < 2; cc++)
          for (int nn = 0; nn == 0 || nn < inch; nn += 4)
            for (int ii = 0; ii < 2; ii++)
              for (int jj = 0; jj < 2; jj++) begin
                tup_t e;
                wr_t  w;
                int   rel;
                logic ft, lt;
                rel = 1 + k;
                if (st_len > 0 && rel >= st_at) rel += st_len;
                ft = (nn == 0) && (ii == 0) && (jj == 0);
                lt = (nn + 4 >= inch) && (ii == 1) && (jj == 1);
                e.cyc = base + rel;
                e.tup = {8'(mm), 8'(rr), 8'(cc), 8'(nn), 4'(ii), 4'(jj), ft, lt};
                q_tup.push_back(e);
                if (lt) begin
                  w.cyc  = base + rel + 3;
                  w.addr = 16'(mm * 4 + rr * 2 + cc);
                  q_wr.push_back(w);
                end
                k++;
              end
  endtask

  task automatic mon(input logic iv, input logic we, input logic dn, input logic st,
                     input logic [41:0] tup, input logic [15:0] addr);
    if (iv) begin
      if (q_tup.size() == 0) chk("tuple_unexpected", 64'(iv), 64'd0);
      else begin
        tup_t e;
        e = q_tup.pop_front();
        chk("tuple_cycle", 64'(cyc), 64'(e.cyc));
        chk("tuple_value", 64'(tup), 64'(e.tup));
      end
    end else if (st && q_tup.size() > 0) begin
      chk("stall_hold", 64'(tup), 64'({q_tup[0].tup[41:2], 2'b00}));
    end
    if (we) begin
      wea_cnt++;
      if (q_wr.size() == 0) chk("wea_unexpected", 64'(we), 64'd0);
      else begin
        wr_t w;
        w = q_wr.pop_front();
        chk("wea_cycle", 64'(cyc), 64'(w.cyc));
        chk("wea_addr", 64'(addr), 64'(w.addr));
      end
    end
    if (dn) done_log.push_back(cyc);
  endtask

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (busy_a || busy_b) busy_cnt++;
    mon(iv_a, we_a, done_a, stall_a, {m_a, r_a, c_a, n_a, i_a, j_a, ft_a, lt_a}, addr_a);
    mon(iv_b, we_b, done_b, stall_b, {m_b, r_b, c_b, n_b, i_b, j_b, ft_b, lt_b}, addr_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int cnt);
    for (int k = 0; k < cnt; k++) tick();
  endtask

  task automatic wait_done(input int want);
    for (int w = 0; w < 400; w++) begin
      if (done_log.size() >= want) break;
      tick();
    end
    chk("done_reached", 64'(done_log.size() >= want), 64'd1);
  endtask

  int t0, nd, nw, nb;

  initial begin
    reset = 1'b1; go_a = 1'b0; stall_a = 1'b0; go_b = 1'b0; stall_b = 1'b0;
    ticks(3);
    chk("reset_a", {m_a, r_a, c_a, n_a, i_a, j_a, iv_a, ft_a, lt_a, we_a, addr_a, busy_a, done_a}, 64'd0);
    chk("reset_b", {m_b, r_b, c_b, n_b, i_b, j_b, iv_b, ft_b, lt_b, we_b, addr_b, busy_b, done_b}, 64'd0);
    reset = 1'b0;
    tick();

    // basic pass
    tick(); t0 = cyc; nd = done_log.size(); nw = wea_cnt; nb = busy_cnt;
    push_pass(t0, 1, 0, 0);
    go_a = 1'b1; tick(); go_a = 1'b0;
    wait_done(nd + 1);
    if (done_log.size() > nd) chk("basic_done_cycle", 64'(done_log[nd]), 64'(t0 + 36));
    chk("basic_busy_cycles", 64'(busy_cnt - nb), 64'd35);
    chk("basic_wea_count", 64'(wea_cnt - nw), 64'd8);
    chk("basic_queues_empty", 64'(q_tup.size() + q_wr.size()), 64'd0);

    // stall during cycles 10..14
    tick(); t0 = cyc; nd = done_log.size(); nw = wea_cnt;
    push_pass(t0, 1, 10, 5);
    go_a = 1'b1; tick(); go_a = 1'b0;
    ticks(9); stall_a = 1'b1;
    ticks(5); stall_a = 1'b0;
    wait_done(nd + 1);
    if (done_log.size() > nd) chk("stall_done_cycle", 64'(done_log[nd]), 64'(t0 + 41));
    chk("stall_wea_count", 64'(wea_cnt - nw), 64'd8);
    chk("stall_queues_empty", 64'(q_tup.size() + q_wr.size()), 64'd0);

    // channel tiling on the IN_CHANNEL=6 instance
    tick(); t0 = cyc; nd = done_log.size(); nw = wea_cnt;
    push_pass(t0, 6, 0, 0);
    go_b = 1'b1; tick(); go_b = 1'b0;
    wait_done(nd + 1);
    if (done_log.size() > nd) chk("tile_done_cycle", 64'(done_log[nd]), 64'(t0 + 68));
    chk("tile_wea_count", 64'(wea_cnt - nw), 64'd8);
    chk("tile_queues_empty", 64'(q_tup.size() + q_wr.size()), 64'd0);

    // reset in cycle 20 aborts the pass
    tick(); t0 = cyc;
    push_pass(t0, 1, 0, 0);
    go_a = 1'b1; tick(); go_a = 1'b0;
    ticks(19); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("abort_outputs", {m_a, r_a, c_a, n_a, i_a, j_a, iv_a, ft_a, lt_a, we_a, addr_a, busy_a, done_a}, 64'd0);
    q_tup.delete(); q_wr.delete();
    nd = done_log.size(); nw = wea_cnt;
    ticks(20);
    chk("abort_no_done", 64'(done_log.size() - nd), 64'd0);
    chk("abort_no_wea", 64'(wea_cnt - nw), 64'd0);
    tick(); t0 = cyc;
    push_pass(t0, 1, 0, 0);
    go_a = 1'b1; tick(); go_a = 1'b0;
    wait_done(nd + 1);
    if (done_log.size() > nd) chk("restart_done_cycle", 64'(done_log[nd]), 64'(t0 + 36));
    chk("restart_queues_empty", 64'(q_tup.size() + q_wr.size()), 64'd0);

    // go held high: back-to-back passes, go ignored outside IDLE
    tick(); t0 = cyc; nd = done_log.size();
    push_pass(t0, 1, 0, 0);
    push_pass(t0 + 37, 1, 0, 0);
    go_a = 1'b1; ticks(60); go_a = 1'b0;
    wait_done(nd + 2);
    if (done_log.size() > nd + 1) begin
      chk("held_done1_cycle", 64'(done_log[nd]), 64'(t0 + 36));
      chk("held_done2_cycle", 64'(done_log[nd + 1]), 64'(t0 + 73));
    end
    ticks(5);
    chk("held_single_done_each", 64'(done_log.size() - nd), 64'd2);
    chk("final_queues_empty", 64'(q_tup.size() + q_wr.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
